// File: rtl/mmio_store_fifo.sv
// Memory-mapped store FIFO for the single-cycle MIPS data bus: stores to DATA are queued
// and drained through a valid/ready port; STATUS/CONTROL give occupancy, overflow and flush.
module mmio_store_fifo #(
  parameter int unsigned   N         = 32,
  parameter int unsigned   DEPTH     = 8,
  parameter logic [N-1:0]  BASE_ADDR = 32'hFFFF0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         memwrite,
  input  logic [N-1:0] dataadr,
  input  logic [N-1:0] writedata,
  output logic         sel,
  output logic [N-1:0] readdata,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  input  logic         out_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [N-1:0] STAT_ADDR = N'(BASE_ADDR + 4);
  localparam logic [N-1:0] CTRL_ADDR = N'(BASE_ADDR + 8);

  logic [N-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic is_data, is_stat, is_ctrl;
  logic full, empty, push, pop, push_ok, flush;

  assign is_data = (dataadr == BASE_ADDR);
  assign is_stat = (dataadr == STAT_ADDR);
  assign is_ctrl = (dataadr == CTRL_ADDR);
  assign sel     = is_data | is_stat | is_ctrl;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push    = memwrite & is_data;
  assign pop     = out_valid & out_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop);
  assign flush   = memwrite & is_ctrl & writedata[0];

  assign out_valid = ~empty;
  assign out_data  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    readdata = '0;
    if (is_stat) begin
      readdata[N-1]    = overflow_q;
      readdata[N-2]    = full;
      readdata[N-3]    = empty;
      readdata[CW-1:0] = count_q;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push & ~push_ok)
      overflow_d = 1'b1;
    if (memwrite & is_stat & writedata[0])
      overflow_d = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok & ~pop)      count_d = count_q + CW'(1);
      else if (pop & ~push_ok) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && push_ok)
      mem_q[wr_ptr_q] <= writedata;
  end

endmodule

// File: tb/tb_mmio_store_fifo.sv
// Directed bench for mmio_store_fifo: vector table for the basic store/drain/overflow
// flows, then hand sequences for flush, unmapped stores, mid-stream reset and a wrap run.
module tb_mmio_store_fifo;

  localparam logic [31:0] B = 32'hFFFF0000;
  localparam logic [31:0] S = 32'hFFFF0004;
  localparam logic [31:0] C = 32'hFFFF0008;

  logic        clk = 1'b0;
  logic        reset, memwrite, out_ready;
  logic [31:0] dataadr, writedata;
  logic        sel, out_valid;
  logic [31:0] readdata, out_data;

  int n_vec = 0;
  int n_bad = 0;

  mmio_store_fifo #(.N(32), .DEPTH(8), .BASE_ADDR(32'hFFFF0000)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .sel(sel), .readdata(readdata),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    logic        es;
    logic [31:0] er;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic we, logic [31:0] adr, logic [31:0] wd, logic rdy,
                              logic ev, logic [31:0] ed, logic es, logic [31:0] er);
    vec_t v;
    v.we = we; v.adr = adr; v.wd = wd; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.es = es; v.er = er;
    return v;
  endfunction

  // Inputs change 1 time unit after a rising edge; outputs are sampled 4 units later.
  task automatic drive(input logic rst, input logic we, input logic [31:0] adr,
                       input logic [31:0] wd, input logic rdy);
    reset = rst; memwrite = we; dataadr = adr; writedata = wd; out_ready = rdy;
    n_vec++;
    #4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  logic [31:0] q[$];

  initial begin
    reset = 1'b1; memwrite = 1'b0; dataadr = '0; writedata = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // reset state
    tbl.push_back(mk(0, S, 0, 0,  0, 32'h0, 1, 32'h2000_0000));
    // two stores, then drain
    tbl.push_back(mk(1, B, 32'h9504, 0,  0, 32'h0, 1, 32'h0));
    tbl.push_back(mk(1, B, 32'h0, 0,     1, 32'h9504, 1, 32'h0));
    tbl.push_back(mk(0, S, 0, 0,  1, 32'h9504, 1, 32'h0000_0002));
    tbl.push_back(mk(0, 0, 0, 1,  1, 32'h9504, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 1,  1, 32'h0, 0, 32'h0));
    tbl.push_back(mk(0, S, 0, 1,  0, 32'h0, 1, 32'h2000_0000));
    // nine stores into an eight-deep FIFO
    tbl.push_back(mk(1, B, 1, 0,  0, 32'h0, 1, 32'h0));
    for (int k = 2; k <= 9; k++)
      tbl.push_back(mk(1, B, 32'(k), 0,  1, 32'h1, 1, 32'h0));
    tbl.push_back(mk(0, S, 0, 0,  1, 32'h1, 1, 32'hC000_0008));
    tbl.push_back(mk(1, S, 1, 0,  1, 32'h1, 1, 32'hC000_0008));
    tbl.push_back(mk(0, S, 0, 0,  1, 32'h1, 1, 32'h4000_0008));
    // push into full FIFO while head pops
    tbl.push_back(mk(1, B, 32'hAA, 1,  1, 32'h1, 1, 32'h0));
    tbl.push_back(mk(0, S, 0, 0,  1, 32'h2, 1, 32'h4000_0008));
    for (int k = 2; k <= 8; k++)
      tbl.push_back(mk(0, 0, 0, 1,  1, 32'(k), 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 1,  1, 32'hAA, 0, 32'h0));
    tbl.push_back(mk(0, S, 0, 0,  0, 32'h0, 1, 32'h2000_0000));

    foreach (tbl[i]) begin
      drive(0, tbl[i].we, tbl[i].adr, tbl[i].wd, tbl[i].rdy);
      cmp($sformatf("v%0d.valid", i), 32'(out_valid), 32'(tbl[i].ev));
      cmp($sformatf("v%0d.data", i), out_data, tbl[i].ed);
      cmp($sformatf("v%0d.sel", i), 32'(sel), 32'(tbl[i].es));
      cmp($sformatf("v%0d.rdata", i), readdata, tbl[i].er);
      tick();
    end

    // flush with a concurrent pop: flush wins, overflow untouched
    for (int k = 0; k < 9; k++) begin
      drive(0, 1, B, 32'h100 + 32'(k), 0);
      tick();
    end
    drive(0, 1, C, 1, 1);
    cmp("flush.ctrl_rd", readdata, 32'h0);
    cmp("flush.ctrl_sel", 32'(sel), 32'h1);
    tick();
    drive(0, 0, S, 0, 1);
    cmp("flush.status", readdata, 32'hA000_0000);
    cmp("flush.valid", 32'(out_valid), 32'h0);
    cmp("flush.data", out_data, 32'h0);
    tick();
    drive(0, 1, S, 1, 0);
    tick();
    drive(0, 1, B, 32'h55, 0);
    tick();
    drive(0, 1, 32'h54, 32'hDEAD, 0);
    cmp("post_flush.data", out_data, 32'h55);
    cmp("ram.sel", 32'(sel), 32'h0);
    cmp("ram.rdata", readdata, 32'h0);
    tick();
    drive(0, 0, S, 0, 0);
    cmp("ram.status", readdata, 32'h0000_0001);
    cmp("ram.data", out_data, 32'h55);
    tick();

    // reset mid-stream discards queued entries
    drive(0, 1, B, 32'h66, 0);
    tick();
    drive(1, 0, S, 0, 0);
    tick();
    drive(0, 1, B, 32'h77, 0);
    cmp("rst.valid", 32'(out_valid), 32'h0);
    cmp("rst.status", readdata, 32'h0);
    tick();
    drive(0, 0, S, 0, 1);
    cmp("rst.first", out_data, 32'h77);
    cmp("rst.count", readdata, 32'h0000_0001);
    tick();

    // random push/pop run crossing pointer wrap, against a queue model
    q.delete();
    for (int c = 0; c < 80; c++) begin
      logic        we, rdy, pop;
      int          pre;
      logic [31:0] wd;
      we  = 1'($urandom_range(0, 1));
      rdy = 1'($urandom_range(0, 2) == 0);
      wd  = $urandom;
      drive(0, we, we ? B : S, wd, rdy);
      cmp($sformatf("rnd%0d.valid", c), 32'(out_valid), 32'(q.size() != 0));
      cmp($sformatf("rnd%0d.data", c), out_data, (q.size() != 0) ? q[0] : 32'h0);
      if (!we)
        cmp($sformatf("rnd%0d.count", c), {28'h0, readdata[3:0]}, 32'(q.size()));
      pre = q.size();
      pop = (pre != 0) && rdy;
      if (pop) void'(q.pop_front());
      if (we && (pre < 8 || pop)) q.push_back(wd);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
